// File: rtl/three_bit_link_pkg.sv
// Shared definitions for the three-signal one-wire serial link (receiver and
// transmitter both import this package).
//   state_t      : link FSM states (PARITY only used when parity is built in)
//   DIV_DEFAULT  : default clock cycles per serial bit
//   IDLE_LEVEL   : line level between frames and of the stop bit
//   START_LEVEL  : line level of the start bit
//   FRAME_BITS   : number of data bits carried per frame (a, b, c)
//   even_parity  : parity bit that makes the data plus parity even
package three_bit_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  localparam int   DIV_DEFAULT = 4;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   FRAME_BITS  = 3;

  function automatic logic even_parity(input logic [FRAME_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/three_bit_serial_rx_bit_timer.sv
// Bit timer for the serial receiver: a down-counter that is loaded with
// either a half-bit or a full-bit interval and raises tick when it reaches 0.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset (count=0)
//   load       : reload the counter this edge
//   half       : with load, reload DIV/2-1 (half bit) instead of DIV-1
//   tick       : count has expired; the owner samples the line this edge
module bit_timer
  import three_bit_link_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic half,
  output logic tick
);

  // Loading N makes tick fire on the (N+1)th edge after the load edge.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= half ? HALF_M1 : FULL_M1;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/three_bit_serial_rx.sv
// Receiver for a one-wire link carrying three logic signals a, b, c.
// Frame: idle-high line, start bit (0), a, b, c, [even parity], stop bit (1);
// every bit lasts DIV clocks. The start bit is re-checked mid-bit to reject
// glitches, and each data bit is sampled at its centre.
// Optional build macro: THREE_BIT_RX_PARITY_EN adds an even-parity bit
// after c; a parity mismatch is reported as a frame error.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   serial_in   : serial line, already synchronous to clk, idles at 1
//   a, b, c     : last good frame's data; change only on a good stop sample
//   valid       : one-cycle strobe, the cycle after a, b, c were loaded
//   frame_err   : one-cycle strobe after a bad stop (or parity) sample
//   busy        : registered (state != IDLE)
// Handshake: valid and frame_err are strobes with no back-pressure. The
// consumer takes a, b, c while valid is high (they also hold afterwards).
module three_bit_serial_rx
  import three_bit_link_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic a,
  output logic b,
  output logic c,
  output logic valid,
  output logic frame_err,
  output logic busy
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BITS - 1);

  state_t                state;
  logic [1:0]            bit_idx;
  logic [FRAME_BITS-1:0] shift;
  logic                  good_q;
  logic                  bad_q;
  logic                  frame_ok;
  logic                  t_load;
  logic                  t_half;
  logic                  tick;

`ifdef THREE_BIT_RX_PARITY_EN
  logic par_bit;
  assign frame_ok = (serial_in == IDLE_LEVEL) && (even_parity(shift) == par_bit);
`else
  assign frame_ok = (serial_in == IDLE_LEVEL);
`endif

  bit_timer #(.DIV(DIV), .CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .half  (t_half),
    .tick  (tick)
  );

  // Timer reloads: half bit on the falling start edge, full bit after every
  // centre sample that leads to another sample.
  always_comb begin
    t_load = 1'b0;
    t_half = 1'b0;
    case (state)
      IDLE:   if (serial_in == START_LEVEL) begin
                t_load = 1'b1;
                t_half = 1'b1;
              end
      START:  if (tick && serial_in == START_LEVEL) t_load = 1'b1;
      DATA:   if (tick) t_load = 1'b1;
`ifdef THREE_BIT_RX_PARITY_EN
      PARITY: if (tick) t_load = 1'b1;
`endif
      default: ;
    endcase
  end

  // The stop decision is held one cycle in good_q/bad_q so the strobes
  // appear the cycle after a, b, c load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef THREE_BIT_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      valid     <= good_q;
      frame_err <= bad_q;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (serial_in == START_LEVEL) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (serial_in == START_LEVEL) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift[bit_idx] <= serial_in;
            if (bit_idx == LAST_IDX) begin
`ifdef THREE_BIT_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 2'd1;
            end
          end
        end
`ifdef THREE_BIT_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bit <= serial_in;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (frame_ok) begin
              a      <= shift[0];
              b      <= shift[1];
              c      <= shift[2];
              good_q <= 1'b1;
            end else begin
              bad_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
